decode_regfile: RTL and testbench
=================================

# decode_regfile

Decode stage and architectural register file of the Y86-64 SEQ processor: the read end of the write-back path. From `icode`, `rA` and `rB` it derives the source and destination register IDs, reads `valA`/`valB` for execute, and on the clock edge commits `valE` and `valM` from write-back into the 15 program registers. It sits between fetch and execute and receives the write-back results.

## Interface
- Parameters:
  - `NREG`, default 15: number of program registers (IDs 0..14); ID 4'hF is RNONE.
  - `W`, default 64: data width.
- Ports:
  - `clk` input 1: single clock, rising-edge.
  - `rst_n` input 1: reset, asynchronous, active-low.
  - `icode` input 4: instruction code of the current instruction.
  - `rA` input 4: register A field.
  - `rB` input 4: register B field.
  - `cnd` input 1: condition result from execute; gates cmovxx write.
  - `wb_en` input 1: commit strobe; writes occur only on an edge where it is high.
  - `valE_in` input W: ALU result to write to `dstE`.
  - `valM_in` input W: memory result to write to `dstM`.
  - `srcA`, `srcB`, `dstE`, `dstM` output 4: decoded register IDs.
  - `valA`, `valB` output W: register read data.

## Operation
- ID decode, combinational; any icode not listed gives RNONE:
  - `srcA`: rA for rrmovq/cmovxx (2), rmmovq (4), OPq (6), pushq (A); RSP=4 for ret (9), popq (B).
  - `srcB`: rB for rmmovq (4), mrmovq (5), OPq (6); RSP for call (8), ret (9), pushq (A), popq (B).
  - `dstE`: rB for irmovq (3) and OPq (6); rB for icode 2 only when `cnd`=1, else RNONE; RSP for 8, 9, A, B.
  - `dstM`: rA for mrmovq (5) and popq (B).
- Reads: `valA`=R[`srcA`], `valB`=R[`srcB`]; a read of RNONE returns 0.
- Writes, on a rising edge with `wb_en`=1: R[`dstE`]<=`valE_in`; R[`dstM`]<=`valM_in`. A write to RNONE is discarded.
- Collision: if `dstE`==`dstM`!=RNONE, `valM_in` wins. This gives popq %rsp its Y86 semantics.
- Write data is taken as a full W-bit value, with no truncation or extension.

## Timing
- Decode and reads are combinational, with zero-cycle latency from inputs and register state.
- A write is visible on `valA`/`valB` in the cycle after the committing edge (default build).
- Reset: all registers go to 0 immediately while `rst_n`=0. Outputs then follow their decode inputs (`valA`/`valB`=0).
- Reset deasserting in the same cycle as `wb_en`: no write on that edge is required. The first guaranteed write is on the following edge.
- With `wb_en`=0, register state holds indefinitely.

## Configuration
- `REGFILE_BYPASS_EN`:
  - Defined: a read whose source matches a destination being written this cycle (`wb_en`=1) returns the incoming data combinationally. When both destinations match, `valM_in` is returned.
  - Undefined: reads always return the pre-edge register contents.

## Structure
- Package `y86_pkg`:
  - icode constants (HALT..POPQ).
  - Register IDs, including `RSP`=4 and `RNONE`=4'hF.
  - OPq ifun constants.
- Sub-module `regfile_core`: 15×W storage with two combinational read ports and two write ports, port-M priority, asynchronous reset and the optional bypass.
- `decode_regfile`: ID decode around `regfile_core`.

## Test plan
- Reset then read: assert `rst_n`=0 for 2 cycles, release; icode=6, rA=0, rB=3 -> `valA`=0, `valB`=0, `dstE`=3.
- irmovq: icode=3, rB=2, valE_in=64'h1234, `wb_en`=1 for one edge -> next cycle, icode=6, rA=2 gives `valA`=64'h1234.
- cmov gating: icode=2, rA=1, rB=5, cnd=0, valE_in=99, one committed edge -> R5 unchanged and `dstE`=F; repeat with cnd=1 -> R5=99.
- popq %rsp collision: icode=B, rA=4, valE_in=64'h108, valM_in=64'hABCD, one edge -> R4=64'hABCD.
- Bypass: write R7=55 and read `srcA`=7 in the same cycle -> `valA`=55 with `REGFILE_BYPASS_EN` defined, old value without it.
- Reset mid-run: R3=77, then `rst_n` low asynchronously mid-cycle -> R3=0 before the next edge; a write on that edge is ignored.

Source files
------------

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 encodings for the SEQ datapath.
//   - icode constants HALT..POPQ
//   - program register IDs, including RSP (4) and RNONE (4'hF)
//   - OPq ifun constants
// No ports; imported with "import y86_pkg::*;".
package y86_pkg;

   // Instruction codes
   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;  // also cmovxx
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   // Register IDs
   localparam logic [3:0] R_RAX   = 4'h0;
   localparam logic [3:0] R_RCX   = 4'h1;
   localparam logic [3:0] R_RDX   = 4'h2;
   localparam logic [3:0] R_RBX   = 4'h3;
   localparam logic [3:0] RSP     = 4'h4;
   localparam logic [3:0] R_RBP   = 4'h5;
   localparam logic [3:0] R_RSI   = 4'h6;
   localparam logic [3:0] R_RDI   = 4'h7;
   localparam logic [3:0] R_R8    = 4'h8;
   localparam logic [3:0] R_R14   = 4'hE;
   localparam logic [3:0] RNONE   = 4'hF;

   // OPq function codes
   localparam logic [3:0] F_ADD = 4'h0;
   localparam logic [3:0] F_SUB = 4'h1;
   localparam logic [3:0] F_AND = 4'h2;
   localparam logic [3:0] F_XOR = 4'h3;

endpackage

// File: rtl/regfile_core.sv
// regfile_core: NREG x W program register storage.
//   clk, rst_n         : rising-edge clock, async active-low reset (clears all)
//   wb_en              : commit strobe for both write ports
//   dstE/valE_in       : write port E
//   dstM/valM_in       : write port M (wins over E on the same ID)
//   srcA/valA, srcB/valB : combinational read ports; RNONE reads as 0
// Build option: REGFILE_BYPASS_EN forwards same-cycle write data to reads.
module regfile_core
   import y86_pkg::*;
#(
   parameter int NREG = 15,
   parameter int W    = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         wb_en,
   input  logic [3:0]   dstE,
   input  logic [3:0]   dstM,
   input  logic [W-1:0] valE_in,
   input  logic [W-1:0] valM_in,
   input  logic [3:0]   srcA,
   input  logic [3:0]   srcB,
   output logic [W-1:0] valA,
   output logic [W-1:0] valB
);

   logic [W-1:0] regs [NREG];

   // NOTE: the architectural state must read 0 out of reset, so every entry
   // is cleared here; this makes the array flops rather than a RAM macro.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (wb_en) begin
         // NOTE: non-blocking writes; with both ports on one ID the later
         // assignment (port M) is the one that lands, giving popq %rsp its value.
         if (dstE != RNONE && 32'(dstE) < NREG) regs[dstE] <= valE_in;
         if (dstM != RNONE && 32'(dstM) < NREG) regs[dstM] <= valM_in;
      end
   end

   // NOTE: each output gets a default first so no path through the block
   // leaves it unassigned (which would infer a latch).
   always_comb begin
      valA = '0;
      if (srcA != RNONE && 32'(srcA) < NREG) valA = regs[srcA];
`ifdef REGFILE_BYPASS_EN
      if (rst_n && wb_en && srcA != RNONE) begin
         if (dstM == srcA)      valA = valM_in;
         else if (dstE == srcA) valA = valE_in;
      end
`endif
   end

   always_comb begin
      valB = '0;
      if (srcB != RNONE && 32'(srcB) < NREG) valB = regs[srcB];
`ifdef REGFILE_BYPASS_EN
      if (rst_n && wb_en && srcB != RNONE) begin
         if (dstM == srcB)      valB = valM_in;
         else if (dstE == srcB) valB = valE_in;
      end
`endif
   end

endmodule

// File: rtl/decode_regfile.sv
// decode_regfile: Y86-64 SEQ decode stage plus register file.
//   clk, rst_n        : rising-edge clock, async active-low reset
//   icode, rA, rB     : fields of the current instruction
//   cnd               : execute condition; enables the cmovxx write
//   wb_en             : write-back commit strobe
//   valE_in, valM_in  : write-back data for dstE / dstM
//   srcA, srcB, dstE, dstM : decoded register IDs (RNONE = 4'hF)
//   valA, valB        : register read data for execute
// Build option: REGFILE_BYPASS_EN (see regfile_core).
module decode_regfile
   import y86_pkg::*;
#(
   parameter int NREG = 15,
   parameter int W    = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [3:0]   icode,
   input  logic [3:0]   rA,
   input  logic [3:0]   rB,
   input  logic         cnd,
   input  logic         wb_en,
   input  logic [W-1:0] valE_in,
   input  logic [W-1:0] valM_in,
   output logic [3:0]   srcA,
   output logic [3:0]   srcB,
   output logic [3:0]   dstE,
   output logic [3:0]   dstM,
   output logic [W-1:0] valA,
   output logic [W-1:0] valB
);

   always_comb begin
      srcA = RNONE;
      srcB = RNONE;
      dstE = RNONE;
      dstM = RNONE;
      case (icode)
         I_RRMOVQ: begin
            srcA = rA;
            dstE = cnd ? rB : RNONE;  // cmovxx not taken writes nothing
         end
         I_IRMOVQ: dstE = rB;
         I_RMMOVQ: begin
            srcA = rA;
            srcB = rB;
         end
         I_MRMOVQ: begin
            srcB = rB;
            dstM = rA;
         end
         I_OPQ: begin
            srcA = rA;
            srcB = rB;
            dstE = rB;
         end
         I_CALL: begin
            srcB = RSP;
            dstE = RSP;
         end
         I_RET: begin
            srcA = RSP;
            srcB = RSP;
            dstE = RSP;
         end
         I_PUSHQ: begin
            srcA = rA;
            srcB = RSP;
            dstE = RSP;
         end
         I_POPQ: begin
            srcA = RSP;
            srcB = RSP;
            dstE = RSP;
            dstM = rA;
         end
         default: ;
      endcase
   end

   regfile_core #(.NREG(NREG), .W(W)) u_core (
      .clk     (clk),
      .rst_n   (rst_n),
      .wb_en   (wb_en),
      .dstE    (dstE),
      .dstM    (dstM),
      .valE_in (valE_in),
      .valM_in (valM_in),
      .srcA    (srcA),
      .srcB    (srcB),
      .valA    (valA),
      .valB    (valB)
   );

endmodule

// File: tb/tb_decode_regfile.sv
// tb_decode_regfile: directed test of decode_regfile with a register-file
// model that is compared against the DUT on every falling clock edge.
module tb_decode_regfile;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  icode = 4'h0, rA = 4'hF, rB = 4'hF;
   logic        cnd = 1'b0, wb_en = 1'b0;
   logic [63:0] valE_in = '0, valM_in = '0;
   logic [3:0]  srcA, srcB, dstE, dstM;
   logic [63:0] valA, valB;

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] m [16];   // model registers; index 15 (RNONE) never written

   decode_regfile #(.NREG(15), .W(64)) dut (
      .clk(clk), .rst_n(rst_n), .icode(icode), .rA(rA), .rB(rB), .cnd(cnd),
      .wb_en(wb_en), .valE_in(valE_in), .valM_in(valM_in),
      .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
      .valA(valA), .valB(valB)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected IDs straight from the decode table
   function automatic logic [3:0] e_srcA(input logic [3:0] ic, input logic [3:0] ra);
      if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
      if (ic inside {4'h9, 4'hB}) return 4'h4;
      return 4'hF;
   endfunction
   function automatic logic [3:0] e_srcB(input logic [3:0] ic, input logic [3:0] rb);
      if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
      if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
      return 4'hF;
   endfunction
   function automatic logic [3:0] e_dstE(input logic [3:0] ic, input logic [3:0] rb, input logic c);
      if (ic inside {4'h3, 4'h6}) return rb;
      if (ic == 4'h2 && c) return rb;
      if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
      return 4'hF;
   endfunction
   function automatic logic [3:0] e_dstM(input logic [3:0] ic, input logic [3:0] ra);
      if (ic inside {4'h5, 4'hB}) return ra;
      return 4'hF;
   endfunction

   function automatic logic [63:0] e_read(input logic [3:0] id);
      logic [63:0] v;
      v = (id == 4'hF) ? 64'd0 : m[id];
`ifdef REGFILE_BYPASS_EN
      if (rst_n && wb_en && id != 4'hF) begin
         if (e_dstM(icode, rA) == id)           v = valM_in;
         else if (e_dstE(icode, rB, cnd) == id) v = valE_in;
      end
`endif
      return v;
   endfunction

   initial for (int i = 0; i < 16; i++) m[i] = '0;

   always @(negedge rst_n) for (int i = 0; i < 16; i++) m[i] = '0;

   // Model commit: E first, then M, so M wins on a shared ID
   always @(posedge clk) begin
      logic [3:0] de, dm;
      if (rst_n && wb_en) begin
         de = e_dstE(icode, rB, cnd);
         dm = e_dstM(icode, rA);
         if (de != 4'hF) m[de] = valE_in;
         if (dm != 4'hF) m[dm] = valM_in;
      end
   end

   always @(negedge clk) begin
      check("srcA", {60'd0, srcA}, {60'd0, e_srcA(icode, rA)});
      check("srcB", {60'd0, srcB}, {60'd0, e_srcB(icode, rB)});
      check("dstE", {60'd0, dstE}, {60'd0, e_dstE(icode, rB, cnd)});
      check("dstM", {60'd0, dstM}, {60'd0, e_dstM(icode, rA)});
      check("valA", valA, e_read(e_srcA(icode, rA)));
      check("valB", valB, e_read(e_srcB(icode, rB)));
   end

   task automatic apply(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                        input logic c, input logic wb, input logic [63:0] ve,
                        input logic [63:0] vm);
      icode = ic; rA = ra; rB = rb; cnd = c; wb_en = wb; valE_in = ve; valM_in = vm;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset then read
      apply(4'h6, 4'h0, 4'h3, 1'b0, 1'b0, 64'd0, 64'd0);
      check("rst_valA", valA, 64'd0);
      check("rst_valB", valB, 64'd0);
      check("rst_dstE", {60'd0, dstE}, 64'd3);
      check("rst_dstM", {60'd0, dstM}, 64'hF);
      tick();

      // irmovq into R2
      apply(4'h3, 4'hF, 4'h2, 1'b0, 1'b1, 64'h1234, 64'd0);
      check("irmovq_dstE", {60'd0, dstE}, 64'd2);
      check("irmovq_srcA", {60'd0, srcA}, 64'hF);
      tick();
      apply(4'h6, 4'h2, 4'h0, 1'b0, 1'b0, 64'd0, 64'd0);
      check("irmovq_read", valA, 64'h1234);
      tick();

      // cmov not taken, then taken
      apply(4'h2, 4'h1, 4'h5, 1'b0, 1'b1, 64'd99, 64'd0);
      check("cmov_nt_dstE", {60'd0, dstE}, 64'hF);
      tick();
      apply(4'h6, 4'h5, 4'h0, 1'b0, 1'b0, 64'd0, 64'd0);
      check("cmov_nt_R5", valA, 64'd0);
      tick();
      apply(4'h2, 4'h1, 4'h5, 1'b1, 1'b1, 64'd99, 64'd0);
      check("cmov_t_dstE", {60'd0, dstE}, 64'd5);
      tick();
      apply(4'h6, 4'h5, 4'h0, 1'b0, 1'b0, 64'd0, 64'd0);
      check("cmov_t_R5", valA, 64'd99);
      tick();

      // popq %rsp: both ports target R4, M wins
      apply(4'hB, 4'h4, 4'hF, 1'b0, 1'b1, 64'h108, 64'hABCD);
      check("popq_dstE", {60'd0, dstE}, 64'd4);
      check("popq_dstM", {60'd0, dstM}, 64'd4);
      tick();
      apply(4'h6, 4'h4, 4'h0, 1'b0, 1'b0, 64'd0, 64'd0);
      check("popq_R4", valA, 64'hABCD);
      tick();

      // Bypass: R7 holds 11, write 55 while reading it
      apply(4'h3, 4'hF, 4'h7, 1'b0, 1'b1, 64'd11, 64'd0);
      tick();
      apply(4'h6, 4'h7, 4'h7, 1'b0, 1'b1, 64'd55, 64'd0);
`ifdef REGFILE_BYPASS_EN
      check("bypass_same", valA, 64'd55);
`else
      check("bypass_same", valA, 64'd11);
`endif
      tick();
      apply(4'h6, 4'h7, 4'h0, 1'b0, 1'b0, 64'd0, 64'd0);
      check("bypass_after", valA, 64'd55);
      tick();

      // Fill every register through mrmovq (dstM) and read back via rmmovq
      for (int i = 0; i < 15; i++) begin
         apply(4'h5, 4'(i), 4'h0, 1'b0, 1'b1, 64'hDEAD, 64'h1000_0000_0000_0000 + 64'(i * 3));
         tick();
      end
      for (int i = 0; i < 15; i++) begin
         apply(4'h4, 4'(i), 4'(14 - i), 1'b0, 1'b0, 64'd0, 64'd0);
         tick();
      end
      check("fill_R14", valB, 64'h1000_0000_0000_0000);  // last read: rB=0 -> R0

      // Every icode with wb_en=0 (decode coverage, no state change)
      for (int ic = 0; ic < 16; ic++) begin
         apply(4'(ic), 4'h3, 4'h6, ic[0], 1'b0, 64'd0, 64'd0);
         tick();
      end

      // call/pushq/ret update RSP; halt and unlisted icodes write nothing
      apply(4'h8, 4'hF, 4'hF, 1'b0, 1'b1, 64'h200, 64'd0);   tick();
      apply(4'hA, 4'h2, 4'hF, 1'b0, 1'b1, 64'h1F8, 64'd0);   tick();
      apply(4'h0, 4'h2, 4'h2, 1'b1, 1'b1, 64'h5555, 64'h6666); tick();
      apply(4'hC, 4'h2, 4'h2, 1'b1, 1'b1, 64'h5555, 64'h6666); tick();
      apply(4'h9, 4'hF, 4'hF, 1'b0, 1'b0, 64'd0, 64'd0);
      check("push_rsp", valA, 64'h1F8);
      tick();

      // Reset mid-run
      apply(4'h3, 4'hF, 4'h3, 1'b0, 1'b1, 64'd77, 64'd0);
      tick();
      apply(4'h6, 4'h3, 4'h3, 1'b0, 1'b1, 64'd88, 64'd0);
      check("pre_rst_R3", valB, 64'd77);
      rst_n = 1'b0;
      #1;
      check("mid_rst_valA", valA, 64'd0);
      check("mid_rst_valB", valB, 64'd0);
      tick();                       // edge with wb_en=1 while in reset
      apply(4'h6, 4'h3, 4'h3, 1'b0, 1'b0, 64'd0, 64'd0);
      rst_n = 1'b1;
      #1;
      check("post_rst_R3", valA, 64'd0);
      tick();
      tick();

      // Hold with wb_en=0 while inputs toggle
      apply(4'h3, 4'hF, 4'h3, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
      tick();
      repeat (4) begin
         apply(4'h3, 4'hF, 4'h3, 1'b0, 1'b0, 64'h1, 64'h2);
         tick();
      end
      apply(4'h6, 4'h3, 4'h0, 1'b0, 1'b0, 64'd0, 64'd0);
      check("hold_R3", valA, 64'hFFFF_FFFF_FFFF_FFFF);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
